proc_ctx_loader: RTL
====================

# proc_ctx_loader

Restores a process's saved context when the control unit decodes a loadProc instruction, the read-back counterpart to the saveProc path that records the current PID. Given a PID, the block walks that process's 32-word context frame in data memory, one read per cycle. It writes the PC slot to the PC register and words 1–31 into the register file through its write port. The pipeline is stalled (`busy`) for the whole sequence.

## Interface
- `ADDR_W`, 10: data-memory word-address width.
- `DATA_W`, 32: data width.
- `PID_W`, 4: process ID width (16 processes).
- `CTX_BASE`, 0: word address of frame 0; must be a multiple of 32·2^PID_W.

- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `flag_loadProc`  in  1: one-cycle request from control unit.
- `pid_in`  in  PID_W: target process ID, sampled with the request.
- `mem_rd`  out  1: data-memory read strobe.
- `mem_addr`  out  ADDR_W: read word address.
- `mem_rdata`  in  DATA_W: read data, valid the cycle after `mem_rd`.
- `rf_we`  out  1: register-file write enable.
- `rf_waddr`  out  5: destination register.
- `rf_wdata`  out  DATA_W: write data.
- `pc_we`  out  1: PC load enable.
- `pc_out`  out  DATA_W: PC value to load.
- `busy`  out  1: stall request to the pipeline.
- `done`  out  1: one-cycle completion pulse.

## Operation
- Frame layout: word 0 holds the saved PC; word k (1..31) holds register $k.
- Frame address: `CTX_BASE + {pid, idx[4:0]}`, modulo 2^ADDR_W.
- States:
  - IDLE → LOAD on `flag_loadProc`. The PID is latched and idx=0.
  - LOAD issues reads for idx 0..31, incrementing idx each cycle. After idx=31 → DRAIN.
  - DRAIN performs the final write-back → DONE.
  - DONE pulses `done` → IDLE.
- Write-back stage: a one-entry register (valid, idx). Its outputs are driven from that register plus `mem_rdata`.
  - idx=0: `pc_we`=1, `pc_out`=`mem_rdata`, `rf_we`=0.
  - idx≥1: `rf_we`=1, `rf_waddr`=idx, `rf_wdata`=`mem_rdata` (except $26, see Configuration).
- `rf_waddr`/`rf_wdata`/`pc_out` are 0 whenever their enable is 0.
- `flag_loadProc` is ignored outside IDLE, including in DONE.
- Register $0 is never written.

## Timing
- Request sampled in cycle 0 (IDLE).
- `mem_rd`=1 in cycles 1–32; `mem_addr` = base+0 … base+31.
- `pc_we` in cycle 2; `rf_we` in cycles 3–33 for $1..$31.
- `busy`=1 in cycles 1–34; `done`=1 in cycle 34 only.
- Back to IDLE in cycle 35; a new request is accepted in cycle 35.
- Minimum period between requests: 35 cycles.
- Reset values: all outputs 0, state IDLE, idx 0, pipeline valid 0.
- Reset mid-sequence: the next cycle shows all strobes 0 and the block is in IDLE. No partial write completes after reset; already-written registers are not rolled back.
- Reset and request in the same cycle: reset wins and the request is dropped.

## Configuration
- `PROC_LOADER_PID_OVERRIDE_EN`
  - Defined: the $26 write uses zero-extended latched PID as data. Memory word 26 is still read, keeping timing unchanged, and its data is discarded.
  - Undefined: $26 is restored from memory like every other register.

## Structure
- Package `proc_ctx_pkg`:
  - state enum (IDLE, LOAD, DRAIN, DONE)
  - `FRAME_WORDS`=32, `PC_SLOT`=0, `PID_REG`=26
- Sub-module `proc_ctx_wb_stage`: the one-entry (valid, idx) write-back register and output steering for PC / register file / PID override.

## Test plan
- PID 3, `CTX_BASE`=0, memory word 96+k = 0x1000+k: `mem_addr` 96..127 in cycles 1–32. `pc_out`=0x1000 in cycle 2. $k = 0x1000+k. `done` in cycle 34.
- PID 3 with `PROC_LOADER_PID_OVERRIDE_EN` defined: $26 = 0x00000003. Undefined: $26 = 0x101A.
- `flag_loadProc` re-asserted with PID 5 in cycles 10 and 34: ignored, no extra reads. Request in cycle 35: accepted, addresses start at 160.
- `rst` in cycle 15:
  - cycle 16: `busy`/`mem_rd`/`rf_we` = 0 and no `done`.
  - registers $1..$13 hold new values; $14+ unchanged.
- PID 15, `ADDR_W`=9, `CTX_BASE`=0: addresses 480..511, no wrap error; PID 0 hits 0..31.
- Back-to-back PIDs 1 then 2: two sequences totalling 70 cycles; the second PC load is from word 64.

Source files
------------

// File: rtl/proc_ctx_pkg.sv
// Shared types and constants for the process-context restore path.
// Optional build macro: PROC_LOADER_PID_OVERRIDE_EN (restore $26 from the latched PID).
package proc_ctx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned FRAME_WORDS = 32;
    localparam int unsigned IDX_W       = $clog2(FRAME_WORDS);
    localparam int unsigned PC_SLOT     = 0;
    localparam int unsigned PID_REG     = 26;

`ifdef PROC_LOADER_PID_OVERRIDE_EN
    localparam bit PID_OVERRIDE_EN = 1'b1;
`else
    localparam bit PID_OVERRIDE_EN = 1'b0;
`endif

endpackage

// File: rtl/proc_ctx_wb_stage.sv
// One-entry write-back register that steers returning frame words to the PC or
// the register file. Honours PROC_LOADER_PID_OVERRIDE_EN through proc_ctx_pkg.
module proc_ctx_wb_stage
    import proc_ctx_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PID_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [PID_W-1:0]  pid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_out
);

    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;

    // Tracks which frame word arrives on mem_rdata this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_idx   <= '0;
        end else begin
            wb_valid <= rd_valid;
            wb_idx   <= rd_idx;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        pc_we    = 1'b0;
        pc_out   = '0;
        if (wb_valid) begin
            if (wb_idx == IDX_W'(PC_SLOT)) begin
                pc_we  = 1'b1;
                pc_out = mem_rdata;
            end else begin
                rf_we    = 1'b1;
                rf_waddr = 5'(wb_idx);
                // Word 26 is still read so timing is identical; only its data is replaced.
                if (PID_OVERRIDE_EN && (wb_idx == IDX_W'(PID_REG))) begin
                    rf_wdata = DATA_W'(pid);
                end else begin
                    rf_wdata = mem_rdata;
                end
            end
        end
    end

endmodule

// File: rtl/proc_ctx_loader.sv
// Walks a process's 32-word context frame and restores PC and $1..$31 on loadProc.
// Optional build macro: PROC_LOADER_PID_OVERRIDE_EN (see proc_ctx_pkg).
module proc_ctx_loader
    import proc_ctx_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PID_W    = 4,
    parameter int unsigned CTX_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_loadProc,
    input  logic [PID_W-1:0]  pid_in,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_out,
    output logic              busy,
    output logic              done
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [PID_W-1:0] pid_q, pid_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            pid_q <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pid_q <= pid_nxt;
        end
    end

    // Requests are only honoured in IDLE; DONE returns to IDLE without looking.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pid_nxt   = pid_q;
        case (state)
            IDLE: begin
                if (flag_loadProc) begin
                    state_nxt = LOAD;
                    pid_nxt   = pid_in;
                    idx_nxt   = '0;
                end
            end
            LOAD: begin
                idx_nxt = idx + IDX_W'(1);
                if (idx == IDX_W'(FRAME_WORDS - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = (state == LOAD);
        mem_addr = '0;
        if (mem_rd) begin
            mem_addr = ADDR_W'(CTX_BASE) + ADDR_W'({pid_q, idx});
        end
        busy = (state != IDLE);
        done = (state == DONE);
    end

    proc_ctx_wb_stage #(
        .DATA_W (DATA_W),
        .PID_W  (PID_W)
    ) u_wb (
        .clk       (clk),
        .rst       (rst),
        .rd_valid  (mem_rd),
        .rd_idx    (idx),
        .pid       (pid_q),
        .mem_rdata (mem_rdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pc_we     (pc_we),
        .pc_out    (pc_out)
    );

endmodule
